fp_add_issuer: RTL and testbench
================================

# fp_add_issuer

Initiator-side companion to the floating-point `adder`. It accepts single-precision add/subtract requests from the Newton-Raphson control path into a small FIFO and drives the adder's operand and `sel` inputs one request at a time. It restarts the adder for each operation, waits for `output_z_stb`, and returns the captured sum with its tag through a valid/ready result port. A watchdog guarantees a response even if the adder never strobes.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, 2..16.
- `TAG_W`, 4: request tag width.
- `TIMEOUT`, 64: WAIT cycles before a forced timeout response; 2..255.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; equals !full.
- `req_a`, `req_b`  in  32  IEEE-754 single operands.
- `req_sel`  in  1  0 = a+b, 1 = a−b; passed to the adder `sel` unchanged.
- `req_tag`  in  TAG_W  opaque tag, returned with the result.
- `add_a`, `add_b`  out  32  to adder `input_a` / `input_b`.
- `add_sel`  out  1  to adder `sel`.
- `add_rst`  out  1  active-high restart pulse to the adder.
- `add_z`  in  32  from adder `output_z`.
- `add_z_stb`  in  1  from adder `output_z_stb`.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer accepts the result.
- `res_z`  out  32  sum, or qNaN on timeout.
- `res_tag`  out  TAG_W  tag of the completed request.
- `res_timeout`  out  1  the result was forced by the watchdog.
- `busy`  out  1  FSM not IDLE, or FIFO non-empty.

## Operation
- FIFO push on `req_valid && req_ready`. Pop occurs only on the IDLE→LOAD or HOLD→LOAD transition. A push and a pop in the same cycle are legal when the FIFO is not full. Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- FSM states are IDLE, LOAD, WAIT and HOLD.
  - IDLE: if the FIFO is non-empty, pop and go to LOAD.
  - LOAD: `add_a`, `add_b` and `add_sel` register the popped entry, `add_rst`=1, and the watchdog counter is cleared. Go to WAIT unconditionally.
  - WAIT: `add_rst`=0 and the counter increments each cycle.
    - On `add_z_stb`=1: capture `add_z` into `res_z`, set `res_timeout`=0 and `res_valid`=1, then go to HOLD.
    - Otherwise, if the counter reaches TIMEOUT−1: set `res_z`=32'h7FC00000, `res_timeout`=1 and `res_valid`=1, then go to HOLD.
    - If the strobe and the timeout coincide, the strobe wins.
  - HOLD: on `res_ready`, clear `res_valid`. Then go to LOAD if the FIFO is non-empty (popping), otherwise go to IDLE.
- A strobe during the LOAD cycle is stale and is ignored.
- Adder drive signals stay stable from LOAD through HOLD.
- `res_tag` is latched at pop time.
- Reset values, while `rst`=0:
  - `req_ready`=0, `add_a`=`add_b`=0, `add_sel`=0, `add_rst`=1.
  - `res_valid`=0, `res_z`=0, `res_tag`=0, `res_timeout`=0, `busy`=0.
  - FIFO empty; FSM in IDLE.
- Reset asserted mid-operation aborts it. Queued requests and the held result are discarded, and no response is produced.

## Timing
- Request accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - LOAD is entered at E1, so `add_rst` is high for cycle E1–E2.
  - WAIT is entered at E2.
- Strobe sampled at edge Ek: `res_valid`=1 from Ek.
- Back-to-back operation: `res_ready` high at edge Eh with the FIFO non-empty gives LOAD from Eh. There is no IDLE bubble.
- Timeout: with no strobe, `res_valid` rises TIMEOUT edges after entering WAIT.
- `req_ready` rises the cycle after a pop from a full FIFO.

## Configuration
- `FP_ISSUE_STATS_EN` defined:
  - Adds output `stat_ops[15:0]`, which counts responses accepted by the consumer.
  - Adds output `stat_timeouts[15:0]`, which counts timeout responses.
  - Both are saturating, reset to 0, and increment on `res_valid && res_ready`.
- `FP_ISSUE_STATS_EN` not defined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Single add: a=41A00000 (20), b=C1200000 (−10), sel=0, tag=3; adder strobes 5 cycles after `add_rst`. Required: `res_z`=41200000, `res_tag`=3, `res_timeout`=0, `add_rst` high exactly one cycle.
- Subtract: a=42200000 (40), b=41F00000 (30), sel=1. Required: `add_sel`=1 held through WAIT, `res_z`=41200000.
- Queue full: push DEPTH+1 requests with tags 0..4 and `res_ready` held low. Required: `req_ready`=0 after 4 pushes, the fifth request is held, results return in tag order, and there is no IDLE between them once `res_ready`=1.
- Timeout: the adder never strobes. Required: `res_valid` exactly TIMEOUT cycles after WAIT entry, `res_z`=7FC00000, `res_timeout`=1. Check that a strobe coinciding with the last count wins.
- Stale strobe and reset: strobe asserted during LOAD is ignored. `rst`=0 asserted mid-WAIT gives all outputs at reset values the next cycle, and no result is produced after release.
- With `FP_ISSUE_STATS_EN`: 3 normal responses plus 1 timeout give `stat_ops`=4 and `stat_timeouts`=1.

Source files
------------

// File: rtl/fp_add_issuer_if.sv
// Request, adder-drive and result signal bundle for fp_add_issuer.
// The slave modport is the issuer's view; the master modport is the environment's.
interface fp_add_issuer_if #(
  parameter int unsigned TAG_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             req_sel;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_sel;
  logic             add_rst;
  logic [31:0]      add_z;
  logic             add_z_stb;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_z;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;
  logic             busy;

  modport master (
    output req_valid, req_a, req_b, req_sel, req_tag, add_z, add_z_stb, res_ready,
    input  req_ready, add_a, add_b, add_sel, add_rst, res_valid, res_z, res_tag, res_timeout,
           busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_tag, add_z, add_z_stb, res_ready,
    output req_ready, add_a, add_b, add_sel, add_rst, res_valid, res_z, res_tag, res_timeout,
           busy
  );
endinterface

// File: rtl/fp_add_issuer.sv
// Queues add/sub requests and issues them one at a time to the FP adder, with a watchdog.
// Optional FP_ISSUE_STATS_EN adds saturating response/timeout counters.
module fp_add_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic            clk,
  input logic            rst,
  fp_add_issuer_if.slave bus
`ifdef FP_ISSUE_STATS_EN
  ,
  output logic [15:0]    stat_ops,
  output logic [15:0]    stat_timeouts
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = 65 + TAG_W;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StHold} state_e;

  state_e           state_q;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [7:0]       cnt_q;
  logic [31:0]      add_a_q, add_b_q, res_z_q;
  logic             add_sel_q, add_rst_q, res_valid_q, res_timeout_q;
  logic [TAG_W-1:0] res_tag_q;

  logic             full, empty, push, pop;
  logic [EW-1:0]    head;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.req_valid & bus.req_ready;
  // Pops only happen when moving into LOAD, so the popped entry is issued straight away.
  assign pop   = ~empty & ((state_q == StIdle) | ((state_q == StHold) & bus.res_ready));
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.req_sel, bus.req_tag, bus.req_a, bus.req_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cnt_q         <= '0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      add_sel_q     <= 1'b0;
      add_rst_q     <= 1'b1;
      res_valid_q   <= 1'b0;
      res_z_q       <= '0;
      res_tag_q     <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;

      add_rst_q <= 1'b0;
      if (pop) begin
        {add_sel_q, res_tag_q, add_a_q, add_b_q} <= head;
        add_rst_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: if (pop) state_q <= StLoad;
        StLoad: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A strobe on the last watchdog count still wins over the timeout.
          if (bus.add_z_stb) begin
            res_z_q       <= bus.add_z;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= StHold;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            res_z_q       <= 32'h7FC0_0000;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= StHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= pop ? StLoad : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = rst & ~full;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.add_sel     = add_sel_q;
  assign bus.add_rst     = add_rst_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_z       = res_z_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.busy        = (state_q != StIdle) | ~empty;

`ifdef FP_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_timeouts_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_ops_q      <= '0;
      stat_timeouts_q <= '0;
    end else if (res_valid_q && bus.res_ready) begin
      if (stat_ops_q != '1) stat_ops_q <= stat_ops_q + 1'b1;
      if (res_timeout_q && (stat_timeouts_q != '1)) stat_timeouts_q <= stat_timeouts_q + 1'b1;
    end
  end

  assign stat_ops      = stat_ops_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_fp_add_issuer.sv
// Directed self-checking bench for fp_add_issuer; the adder is played by hand-driven strobes.
module tb_fp_add_issuer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 64;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

`ifdef FP_ISSUE_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_timeouts;
`endif

  fp_add_issuer_if #(.TAG_W(TAG_W)) bus ();

  fp_add_issuer #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef FP_ISSUE_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_timeouts(stat_timeouts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic sel,
                          input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sel   = sel;
    bus.req_tag   = tag;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] z);
    bus.add_z     = z;
    bus.add_z_stb = 1'b1;
    tick();
    bus.add_z_stb = 1'b0;
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'h0);
    chk({tag, "_add_a"}, 64'(bus.add_a), 64'h0);
    chk({tag, "_add_b"}, 64'(bus.add_b), 64'h0);
    chk({tag, "_add_sel"}, 64'(bus.add_sel), 64'h0);
    chk({tag, "_add_rst"}, 64'(bus.add_rst), 64'h1);
    chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'h0);
    chk({tag, "_res_z"}, 64'(bus.res_z), 64'h0);
    chk({tag, "_res_tag"}, 64'(bus.res_tag), 64'h0);
    chk({tag, "_res_timeout"}, 64'(bus.res_timeout), 64'h0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sel = 1'b0;
    bus.req_tag = '0;
    bus.add_z = '0;
    bus.add_z_stb = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");

    rst = 1'b1;
    tick();
    chk("post_reset_ready", 64'(bus.req_ready), 64'h1);
    chk("post_reset_add_rst", 64'(bus.add_rst), 64'h0);

    // Single add: 20 + (-10), strobe 5 cycles after add_rst rises.
    push_one(32'h41A0_0000, 32'hC120_0000, 1'b0, 4'd3);
    chk("add_idle_rst", 64'(bus.add_rst), 64'h0);
    chk("add_busy", 64'(bus.busy), 64'h1);
    tick();
    chk("add_load_rst", 64'(bus.add_rst), 64'h1);
    chk("add_load_a", 64'(bus.add_a), 64'h41A0_0000);
    chk("add_load_b", 64'(bus.add_b), 64'hC120_0000);
    chk("add_load_sel", 64'(bus.add_sel), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("add_wait_rst", 64'(bus.add_rst), 64'h0);
      chk("add_wait_valid", 64'(bus.res_valid), 64'h0);
    end
    strobe(32'h4120_0000);
    chk("add_valid", 64'(bus.res_valid), 64'h1);
    chk("add_z", 64'(bus.res_z), 64'h4120_0000);
    chk("add_tag", 64'(bus.res_tag), 64'h3);
    chk("add_timeout", 64'(bus.res_timeout), 64'h0);
    chk("add_hold_rst", 64'(bus.add_rst), 64'h0);
    accept();
    chk("add_done_valid", 64'(bus.res_valid), 64'h0);
    chk("add_done_busy", 64'(bus.busy), 64'h0);

    // Subtract: 40 - 30.
    push_one(32'h4220_0000, 32'h41F0_0000, 1'b1, 4'd5);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sub_wait_sel", 64'(bus.add_sel), 64'h1);
    end
    strobe(32'h4120_0000);
    chk("sub_z", 64'(bus.res_z), 64'h4120_0000);
    chk("sub_tag", 64'(bus.res_tag), 64'h5);
    chk("sub_hold_sel", 64'(bus.add_sel), 64'h1);
    chk("sub_hold_a", 64'(bus.add_a), 64'h4220_0000);
    accept();

    // Queue full: park one result in HOLD, then push tags 0..4.
    push_one(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd7);
    tick();
    tick();
    strobe(32'h4000_0000);
    chk("q_pre_valid", 64'(bus.res_valid), 64'h1);
    for (int i = 0; i < 4; i++) begin
      chk("q_fill_ready", 64'(bus.req_ready), 64'h1);
      push_one(32'h4000_0000 + 32'(i), 32'h0, 1'b0, 4'(i));
    end
    chk("q_full_ready", 64'(bus.req_ready), 64'h0);
    bus.req_valid = 1'b1;
    bus.req_a = 32'h4000_0004;
    bus.req_tag = 4'd4;
    tick();
    chk("q_held_ready", 64'(bus.req_ready), 64'h0);
    chk("q_held_tag", 64'(bus.res_tag), 64'h7);
    chk("q_held_z", 64'(bus.res_z), 64'h4000_0000);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("q_pop_ready", 64'(bus.req_ready), 64'h1);
    chk("q_pop_load_rst", 64'(bus.add_rst), 64'h1);
    chk("q_pop_tag", 64'(bus.res_tag), 64'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("q_refull_ready", 64'(bus.req_ready), 64'h0);
    for (int k = 0; k < 5; k++) begin
      strobe(32'h4100_0000 + 32'(k));
      chk("q_res_valid", 64'(bus.res_valid), 64'h1);
      chk("q_res_tag", 64'(bus.res_tag), 64'(k));
      chk("q_res_z", 64'(bus.res_z), 64'h4100_0000 + 64'(k));
      chk("q_res_a", 64'(bus.add_a), 64'h4000_0000 + 64'(k));
      accept();
      if (k < 4) begin
        chk("q_no_bubble_rst", 64'(bus.add_rst), 64'h1);
        chk("q_next_tag", 64'(bus.res_tag), 64'(k + 1));
        tick();
      end else begin
        chk("q_end_busy", 64'(bus.busy), 64'h0);
      end
    end

    // Timeout with no strobe.
    push_one(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd9);
    tick();
    tick();
    for (int i = 1; i < int'(TIMEOUT); i++) tick();
    chk("to_before_valid", 64'(bus.res_valid), 64'h0);
    tick();
    chk("to_valid", 64'(bus.res_valid), 64'h1);
    chk("to_z", 64'(bus.res_z), 64'h7FC0_0000);
    chk("to_flag", 64'(bus.res_timeout), 64'h1);
    chk("to_tag", 64'(bus.res_tag), 64'h9);
    accept();

    // Strobe on the last watchdog count wins.
    push_one(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd10);
    tick();
    tick();
    for (int i = 1; i < int'(TIMEOUT); i++) tick();
    chk("tie_before_valid", 64'(bus.res_valid), 64'h0);
    strobe(32'h4040_0000);
    chk("tie_valid", 64'(bus.res_valid), 64'h1);
    chk("tie_z", 64'(bus.res_z), 64'h4040_0000);
    chk("tie_flag", 64'(bus.res_timeout), 64'h0);
    accept();

`ifdef FP_ISSUE_STATS_EN
    chk("stat_ops", 64'(stat_ops), 64'd10);
    chk("stat_timeouts", 64'(stat_timeouts), 64'd1);
`endif

    // Stale strobe during LOAD, then reset mid-WAIT with a request queued.
    push_one(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd11);
    tick();
    chk("stale_load_rst", 64'(bus.add_rst), 64'h1);
    strobe(32'hDEAD_BEEF);
    chk("stale_valid", 64'(bus.res_valid), 64'h0);
    tick();
    tick();
    chk("stale_wait_valid", 64'(bus.res_valid), 64'h0);
    push_one(32'h4000_0000, 32'h4000_0000, 1'b0, 4'd12);
    rst = 1'b0;
    tick();
    chk_reset_outputs("midrst");
`ifdef FP_ISSUE_STATS_EN
    chk("midrst_stat_ops", 64'(stat_ops), 64'd0);
`endif
    rst = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < int'(TIMEOUT) + 16; i++) begin
      tick();
      if (bus.res_valid !== 1'b0) chk("post_rst_no_result", 64'(bus.res_valid), 64'h0);
    end
    bus.res_ready = 1'b0;
    chk("post_rst_valid", 64'(bus.res_valid), 64'h0);
    chk("post_rst_busy", 64'(bus.busy), 64'h0);
    chk("post_rst_ready", 64'(bus.req_ready), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
